// File: rtl/fetch_defs_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings, word width and PC defaults.
package fetch_defs_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEF_PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with next-PC selection: redirect target, sequential step, or hold.
module fetch_pc_gen
    import fetch_defs_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [WORD_W-1:0] PC_STEP  = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_pc,
    input  logic              step,
    output logic [WORD_W-1:0] pc_q
);

    logic [WORD_W-1:0] pc_r;
    logic [WORD_W-1:0] pc_nxt_s;

    // Next-PC mux; a redirect overrides a sequential step, arithmetic wraps at 2^32.
    always_comb begin
        pc_nxt_s = pc_r;
        if (load) begin
            pc_nxt_s = load_pc;
        end else if (step) begin
            pc_nxt_s = pc_r + PC_STEP;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_nxt_s;
        end
    end

    assign pc_q = pc_r;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, captures Instruction_MEM data into the IF/ID register, BOOT/RUN/HALT control.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky fetch_misalign output that halts on unaligned redirects.
module instr_fetch_stage
    import fetch_defs_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [WORD_W-1:0] PC_STEP  = DEF_PC_STEP,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic              fetch_misalign,
`endif
    output logic [WORD_W-1:0] imem_a,
    input  logic [WORD_W-1:0] imem_rd,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt_req,
    input  logic              resume,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_instr,
    output logic [WORD_W-1:0] out_pc,
    output logic [WORD_W-1:0] out_pc_plus4,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic              halted
);

    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;
    logic [WORD_W-1:0] pc_q_s;
    logic              redirect_s;
    logic              capture_s;
    logic              clear_s;
    logic              xfer_s;
    logic              misalign_set_s;
    logic              resume_ok_s;
    logic              out_valid_r;
    logic [WORD_W-1:0] out_instr_r;
    logic [WORD_W-1:0] out_pc_r;
    logic [WORD_W-1:0] out_pc_plus4_r;
    logic [CNT_W-1:0]  fetch_cnt_r;

    // Redirects are ignored during BOOT so nothing happens on the reset-release edge.
    assign redirect_s = redirect_valid && (state_r != ST_BOOT);

`ifdef FETCH_ALIGN_CHECK_EN
    logic fetch_misalign_r;

    assign misalign_set_s = redirect_s && (redirect_pc[1:0] != 2'b00);
    assign resume_ok_s    = !fetch_misalign_r;

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_misalign_r <= 1'b0;
        end else if (misalign_set_s) begin
            fetch_misalign_r <= 1'b1;
        end else begin
            fetch_misalign_r <= fetch_misalign_r;
        end
    end

    assign fetch_misalign = fetch_misalign_r;
`else
    assign misalign_set_s = 1'b0;
    assign resume_ok_s    = 1'b1;
`endif

    // Next-state and datapath control; a redirect flushes the entry in flight even if decode accepts it.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        clear_s     = 1'b0;
        xfer_s      = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN, ST_HALT: begin
                if (redirect_s) begin
                    clear_s = 1'b1;
                end else begin
                    xfer_s = out_valid_r && out_ready;
                    if ((state_r == ST_RUN) && !halt_req) begin
                        capture_s = !out_valid_r || out_ready;
                    end else begin
                        clear_s = out_valid_r && out_ready;
                    end
                end
                if (misalign_set_s || halt_req) begin
                    state_nxt_s = ST_HALT;
                end else if (state_r == ST_HALT) begin
                    state_nxt_s = (resume && resume_ok_s) ? ST_RUN : ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    fetch_pc_gen #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redirect_s),
        .load_pc (redirect_pc),
        .step    (capture_s),
        .pc_q    (pc_q_s)
    );

    // IF/ID register and accepted-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r    <= 1'b0;
            out_instr_r    <= 32'h0000_0000;
            out_pc_r       <= 32'h0000_0000;
            out_pc_plus4_r <= 32'h0000_0000;
            fetch_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (capture_s) begin
                out_valid_r    <= 1'b1;
                out_instr_r    <= imem_rd;
                out_pc_r       <= pc_q_s;
                out_pc_plus4_r <= pc_q_s + PC_STEP;
            end else if (clear_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (xfer_s) begin
                fetch_cnt_r <= fetch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                fetch_cnt_r <= fetch_cnt_r;
            end
        end
    end

    assign imem_a       = pc_q_s;
    assign out_valid    = out_valid_r;
    assign out_instr    = out_instr_r;
    assign out_pc       = out_pc_r;
    assign out_pc_plus4 = out_pc_plus4_r;
    assign fetch_cnt    = fetch_cnt_r;
    assign halted       = (state_r == ST_HALT);

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Fetch stage directly upstream of Instruction_MEM.
- Owns the program counter and drives the memory's 32-bit address port `a`. Captures the combinational read data `rd` into an IF/ID output register.
- Presents instruction plus PC to decode through a valid/ready handshake, with stall, redirect (branch/jump) and halt control.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.
- CNT_W, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_a  out  32  address to Instruction_MEM `a`; equals pc_q (combinational from register)
- imem_rd  in  32  instruction from Instruction_MEM `rd`; valid same cycle as imem_a
- redirect_valid  in  1  load redirect_pc into PC this cycle
- redirect_pc  in  32  branch/jump target
- halt_req  in  1  stop issuing new fetches
- resume  in  1  leave HALT
- out_valid  out  1  IF/ID entry valid
- out_ready  in  1  decode accepts entry
- out_instr  out  32  captured instruction
- out_pc  out  32  PC of out_instr
- out_pc_plus4  out  32  out_pc + PC_STEP
- fetch_cnt  out  CNT_W  count of instructions accepted by decode (wraps)
- halted  out  1  state == HALT

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC; out_valid=0; out_instr=0; out_pc=0; out_pc_plus4=0; fetch_cnt=0.
  - state=BOOT; halted=0.
- States are BOOT, RUN and HALT.
- BOOT:
  - One cycle after reset release, no fetch, out_valid stays 0.
  - Then → RUN, so the first fetch is never taken during the reset-release edge.
- RUN:
  - advance = !out_valid || out_ready.
  - If advance and no redirect:
    - out_instr<=imem_rd; out_pc<=pc_q; out_pc_plus4<=pc_q+PC_STEP; out_valid<=1; pc_q<=pc_q+PC_STEP.
  - If !advance (decode stall): pc_q and all out_* hold; imem_a stable.
- Redirect (redirect_valid=1, any state except BOOT):
  - pc_q<=redirect_pc; out_valid<=0, which flushes the entry in flight even if out_ready=1 that cycle. That entry is not counted.
  - Next fetch from redirect_pc occurs the following cycle: exactly one bubble.
  - Redirect beats stall and halt_req in the same cycle. halt_req still takes effect: state→HALT with pc_q=redirect_pc.
- Handshake accounting:
  - Transfer occurs when out_valid && out_ready && !redirect_valid; fetch_cnt increments by 1 and wraps at 2^CNT_W.
  - out_* never change while out_valid=1 && out_ready=0 && !redirect_valid.
- halt_req in RUN:
  - No new capture that cycle; state→HALT.
  - An existing valid entry stays until accepted, then out_valid<=0.
- HALT:
  - pc_q holds (it may be loaded by redirect); no captures.
  - resume=1 → RUN next cycle, with first capture in the cycle after.
  - halt_req and resume together: halt wins.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0, no flag.
- Latency: imem_a→out_valid is 1 cycle; the pipeline sustains 1 instr/cycle with out_ready tied 1.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Extra output port fetch_misalign (1 bit, reset 0).
  - Redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 (sticky until reset), loads pc_q but forces state→HALT with out_valid<=0. resume is ignored while fetch_misalign=1.
- Undefined: no port; misaligned targets are loaded and fetched as-is; imem_a carries low bits unchanged.

Decomposition:
- Shared package/header fetch_defs holds:
  - state encodings (BOOT=2'd0, RUN=2'd1, HALT=2'd2)
  - default RESET_PC
  - PC_STEP
  - the 32-bit word-width constant
- One natural sub-module, fetch_pc_gen: next-PC mux (redirect / +PC_STEP / hold) plus pc_q register.
- The stage keeps the FSM, IF/ID register and counter.

Test Plan:
- Reset release, out_ready=1, memory word i = 32'h1000_0000+i: out_pc goes 0,4,8,... and out_instr goes 1000_0000, 1000_0001,...; first out_valid two cycles after rst_n rises; fetch_cnt=3 after 3 transfers.
- Stall: out_ready=0 for 3 cycles while out_pc=8: out_instr/out_pc/imem_a held (imem_a=12); resume gives out_pc=12 next with no skipped or duplicated PC.
- Redirect to 32'h40 while out_valid=1, out_ready=1: entry not counted; one bubble cycle out_valid=0; next out_pc=0x40, out_pc_plus4=0x44.
- halt_req at out_pc=4 with out_ready=0 for 2 cycles: entry held, then accepted, then out_valid=0, halted=1; resume → next out_pc=8.
- Mid-operation reset: rst_n low asynchronously between edges → out_valid=0, imem_a=RESET_PC immediately; fetch_cnt=0.
- With FETCH_ALIGN_CHECK_EN, redirect_pc=32'h42: fetch_misalign=1, halted=1, out_valid=0; resume has no effect; PC 32'hFFFF_FFFC wraps to 0 (run separately without the macro).
